// File: rtl/rf_pkg.sv
// rf_pkg: shared constants for the integer register-file write-back path.
//   RF_ADDR_W / RF_DATA_W : register address and data widths
//   RF_WB_N               : number of write-back requesters
//   WB_ALU/WB_LSU/WB_MISC : requester indices on the arbiter's req vector
//   rr_ptr_w()            : width of a round-robin pointer for n requesters
package rf_pkg;

  localparam int RF_ADDR_W = 5;
  localparam int RF_DATA_W = 32;
  localparam int RF_WB_N   = 3;

  localparam int WB_ALU  = 0;
  localparam int WB_LSU  = 1;
  localparam int WB_MISC = 2;

  function automatic int rr_ptr_w(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/rr_arbiter.sv
// rr_arbiter: N-way round-robin grant, purely combinational.
// Ports:
//   i_req        [N]  request vector
//   i_rr_ptr     [PW] index with highest priority this cycle
//   o_grant      [N]  one-hot grant (zero when no request)
//   o_grant_idx  [PW] index of the granted requester
//   o_grant_vld  [1]  any request granted
module rr_arbiter
  import rf_pkg::*;
#(
  parameter int N  = RF_WB_N,
  parameter int PW = rr_ptr_w(N)
) (
  input  logic [N-1:0]  i_req,
  input  logic [PW-1:0] i_rr_ptr,
  output logic [N-1:0]  o_grant,
  output logic [PW-1:0] o_grant_idx,
  output logic          o_grant_vld
);

  int w_cand;

  // Scan upward from the pointer, wrapping modulo N; first hit wins.
  always_comb begin
    o_grant     = '0;
    o_grant_idx = '0;
    o_grant_vld = 1'b0;
    w_cand      = 0;
    for (int k = 0; k < N; k++) begin
      w_cand = int'(i_rr_ptr) + k;
      if (w_cand >= N) w_cand = w_cand - N;
      if (!o_grant_vld && i_req[w_cand]) begin
        o_grant[w_cand] = 1'b1;
        o_grant_idx     = PW'(w_cand);
        o_grant_vld     = 1'b1;
      end
    end
  end

endmodule

// File: rtl/rf_wb_arbiter.sv
// rf_wb_arbiter: shares the register file's single write port between N
// write-back sources with round-robin arbitration, and optionally keeps a
// busy scoreboard of in-flight destination registers for RAW stalls.
// Build option: define RF_WB_SCOREBOARD_EN to build the scoreboard; without
// it busy_A/busy_B are tied low and rsv_*/q_addr_* are ignored.
// Ports:
//   clk, n_reset           clock, asynchronous active-low reset
//   req/req_addr/req_data  per-requester request, address, data (packed)
//   ack                    one-hot combinational grant
//   wr_en/w_addr/w_data    registered register-file write port
//   rsv_en/rsv_addr        reserve a destination register
//   q_addr_A/q_addr_B      scoreboard query addresses
//   busy_A/busy_B          stored busy bits for the query addresses
module rf_wb_arbiter
  import rf_pkg::*;
#(
  parameter int N = RF_WB_N,
  parameter int W = RF_ADDR_W,
  parameter int B = RF_DATA_W
) (
  input  logic           clk,
  input  logic           n_reset,
  input  logic [N-1:0]   req,
  input  logic [N*W-1:0] req_addr,
  input  logic [N*B-1:0] req_data,
  output logic [N-1:0]   ack,
  output logic           wr_en,
  output logic [W-1:0]   w_addr,
  output logic [B-1:0]   w_data,
  input  logic           rsv_en,
  input  logic [W-1:0]   rsv_addr,
  input  logic [W-1:0]   q_addr_A,
  input  logic [W-1:0]   q_addr_B,
  output logic           busy_A,
  output logic           busy_B
);

  localparam int PW = rr_ptr_w(N);

  logic [PW-1:0] r_rr_ptr;
  logic [N-1:0]  w_grant;
  logic [PW-1:0] w_grant_idx;
  logic          w_grant_vld;
  logic [W-1:0]  w_sel_addr;
  logic [B-1:0]  w_sel_data;
  logic          r_wr_en;
  logic [W-1:0]  r_w_addr;
  logic [B-1:0]  r_w_data;

  rr_arbiter #(.N(N), .PW(PW)) u_rr (
    .i_req       (req),
    .i_rr_ptr    (r_rr_ptr),
    .o_grant     (w_grant),
    .o_grant_idx (w_grant_idx),
    .o_grant_vld (w_grant_vld)
  );

  // Grant is suppressed while reset is held so no requester retires a
  // transaction that the write port will never see.
  assign ack = w_grant & {N{n_reset}};

  // One-hot grant makes an AND-OR mux sufficient.
  always_comb begin
    w_sel_addr = '0;
    w_sel_data = '0;
    for (int i = 0; i < N; i++) begin
      w_sel_addr = w_sel_addr | ({W{w_grant[i]}} & req_addr[i*W +: W]);
      w_sel_data = w_sel_data | ({B{w_grant[i]}} & req_data[i*B +: B]);
    end
  end

  always_ff @(posedge clk or negedge n_reset) begin
    if (!n_reset) begin
      r_rr_ptr <= '0;
      r_wr_en  <= 1'b0;
      r_w_addr <= '0;
      r_w_data <= '0;
    end else if (w_grant_vld) begin
      r_rr_ptr <= (w_grant_idx == PW'(N-1)) ? '0 : w_grant_idx + PW'(1);
      // x0 writes are acked but never reach the file.
      r_wr_en  <= |w_sel_addr;
      r_w_addr <= w_sel_addr;
      r_w_data <= w_sel_data;
    end else begin
      r_wr_en  <= 1'b0;
    end
  end

  assign wr_en  = r_wr_en;
  assign w_addr = r_w_addr;
  assign w_data = r_w_data;

`ifdef RF_WB_SCOREBOARD_EN
  localparam int NREG = 1 << W;

  logic [NREG-1:0] r_busy;
  logic [NREG-1:0] w_busy_next;

  // Commit clears first so a same-cycle reserve of the same register wins.
  always_comb begin
    w_busy_next = r_busy;
    if (r_wr_en) w_busy_next[r_w_addr] = 1'b0;
    if (rsv_en)  w_busy_next[rsv_addr] = 1'b1;
    w_busy_next[0] = 1'b0;
  end

  always_ff @(posedge clk or negedge n_reset) begin
    if (!n_reset) r_busy <= '0;
    else          r_busy <= w_busy_next;
  end

  // Stored bits only: a commit in flight this cycle still reads busy.
  assign busy_A = r_busy[q_addr_A];
  assign busy_B = r_busy[q_addr_B];
`else
  logic w_unused_sb;
  assign w_unused_sb = ^{rsv_en, rsv_addr, q_addr_A, q_addr_B};
  assign busy_A = 1'b0;
  assign busy_B = 1'b0;
`endif

endmodule

// File: tb/tb_rf_wb_arbiter.sv
module tb_rf_wb_arbiter;

  localparam int N = 3;
  localparam int W = 5;
  localparam int B = 32;

`ifdef RF_WB_SCOREBOARD_EN
  localparam bit SB = 1'b1;
`else
  localparam bit SB = 1'b0;
`endif

  logic           clk = 1'b0;
  logic           n_reset;
  logic [N-1:0]   req;
  logic [N*W-1:0] req_addr;
  logic [N*B-1:0] req_data;
  logic [N-1:0]   ack;
  logic           wr_en;
  logic [W-1:0]   w_addr;
  logic [B-1:0]   w_data;
  logic           rsv_en;
  logic [W-1:0]   rsv_addr;
  logic [W-1:0]   q_addr_A;
  logic [W-1:0]   q_addr_B;
  logic           busy_A;
  logic           busy_B;

  int errors = 0;
  int checks = 0;

  rf_wb_arbiter #(.N(N), .W(W), .B(B)) dut (
    .clk      (clk),
    .n_reset  (n_reset),
    .req      (req),
    .req_addr (req_addr),
    .req_data (req_data),
    .ack      (ack),
    .wr_en    (wr_en),
    .w_addr   (w_addr),
    .w_data   (w_data),
    .rsv_en   (rsv_en),
    .rsv_addr (rsv_addr),
    .q_addr_A (q_addr_A),
    .q_addr_B (q_addr_B),
    .busy_A   (busy_A),
    .busy_B   (busy_B)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  typedef struct {
    logic [N-1:0]   req;
    logic [N*W-1:0] addr;
    logic [N*B-1:0] data;
    logic [N-1:0]   ack;
    logic           wr;
    logic [W-1:0]   wa;
    logic [B-1:0]   wd;
  } vec_t;

  vec_t tbl[13];

  // Reference model state (abstract: integer pointer, flat busy array).
  int         m_ptr;
  bit         m_wr;
  logic [4:0] m_addr;
  logic [31:0] m_data;
  bit         m_busy[32];

  bit         pend[N];
  logic [4:0] pa[N];
  logic [31:0] pd[N];

  initial begin
    logic [14:0] a3;
    logic [95:0] d3;
    int          win;
    logic [2:0]  exp_ack;

    a3 = {5'd3, 5'd2, 5'd1};
    d3 = {32'h33, 32'h22, 32'h11};
    for (int k = 0; k < 4; k++) tbl[k] = '{3'b000, 15'd0, 96'd0, 3'b000, 1'b0, 5'd0, 32'd0};
    tbl[4]  = '{3'b010, {5'd0, 5'd7, 5'd0}, {32'd0, 32'hDEADBEEF, 32'd0}, 3'b010, 1'b1, 5'd7, 32'hDEADBEEF};
    tbl[5]  = '{3'b111, a3, d3, 3'b100, 1'b1, 5'd3, 32'h33};
    tbl[6]  = '{3'b111, a3, d3, 3'b001, 1'b1, 5'd1, 32'h11};
    tbl[7]  = '{3'b111, a3, d3, 3'b010, 1'b1, 5'd2, 32'h22};
    tbl[8]  = '{3'b111, a3, d3, 3'b100, 1'b1, 5'd3, 32'h33};
    tbl[9]  = '{3'b111, a3, d3, 3'b001, 1'b1, 5'd1, 32'h11};
    tbl[10] = '{3'b101, a3, d3, 3'b100, 1'b1, 5'd3, 32'h33};
    tbl[11] = '{3'b001, 15'd0, {32'd0, 32'd0, 32'h5}, 3'b001, 1'b0, 5'd0, 32'h5};
    tbl[12] = '{3'b000, 15'd0, 96'd0, 3'b000, 1'b0, 5'd0, 32'h5};

    // Reset with every requester asserting: no ack may escape.
    n_reset = 1'b0; req = 3'b111; req_addr = a3; req_data = d3;
    rsv_en = 1'b0; rsv_addr = '0; q_addr_A = 5'd1; q_addr_B = 5'd2;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_ack", ack, 3'b000);
    chk("rst_wr_en", wr_en, 1'b0);
    chk("rst_w_addr", w_addr, 5'd0);
    chk("rst_w_data", w_data, 32'd0);
    chk("rst_busy_A", busy_A, 1'b0);
    req = 3'b000;
    @(negedge clk);
    n_reset = 1'b1;
    @(posedge clk);
    #1;

    // Table-driven directed vectors.
    for (int k = 0; k < 13; k++) begin
      req = tbl[k].req; req_addr = tbl[k].addr; req_data = tbl[k].data;
      #2;
      chk($sformatf("vec%0d_ack", k), ack, tbl[k].ack);
      @(posedge clk);
      #1;
      chk($sformatf("vec%0d_wr_en", k), wr_en, tbl[k].wr);
      chk($sformatf("vec%0d_w_addr", k), w_addr, tbl[k].wa);
      chk($sformatf("vec%0d_w_data", k), w_data, tbl[k].wd);
      $display("vec %0d req=%b ack=%b wr_en=%b w_addr=%0d w_data=%h", k, tbl[k].req, ack, wr_en, w_addr, w_data);
    end

    // Reserve x5, then write back to x5: busy clears two cycles after ack.
    req = 3'b000; rsv_en = 1'b1; rsv_addr = 5'd5; q_addr_A = 5'd5;
    #2 chk("sbA_pre_busy", busy_A, 1'b0);
    @(posedge clk); #1;
    rsv_en = 1'b0;
    #2 chk("sbA_rsv_busy", busy_A, SB);
    @(posedge clk); #1;
    req = 3'b010; req_addr = {5'd0, 5'd5, 5'd0}; req_data = {32'd0, 32'h55, 32'd0};
    #2 chk("sbA_ack", ack, 3'b010);
    chk("sbA_t_busy", busy_A, SB);
    @(posedge clk); #1;
    req = 3'b000;
    chk("sbA_t1_wr_en", wr_en, 1'b1);
    chk("sbA_t1_w_addr", w_addr, 5'd5);
    #2 chk("sbA_t1_busy", busy_A, SB);
    @(posedge clk); #1;
    chk("sbA_t2_busy", busy_A, 1'b0);
    $display("seq sb_clear: busy_A=%b after commit of x5", busy_A);

    // Reserve and commit of x5 in the same cycle: reserve wins.
    req = 3'b010;
    #2 chk("sbB_ack", ack, 3'b010);
    @(posedge clk); #1;
    req = 3'b000; rsv_en = 1'b1; rsv_addr = 5'd5;
    chk("sbB_wr_en", wr_en, 1'b1);
    @(posedge clk); #1;
    rsv_en = 1'b0;
    chk("sbB_busy", busy_A, SB);
    $display("seq sb_rsv_commit: busy_A=%b", busy_A);

    // Async reset mid-cycle while a write is on the port and x9 is busy.
    rsv_en = 1'b1; rsv_addr = 5'd9; q_addr_B = 5'd9;
    req = 3'b010; req_addr = {5'd0, 5'd10, 5'd0}; req_data = {32'd0, 32'hA, 32'd0};
    #2 chk("rstC_ack", ack, 3'b010);
    @(posedge clk); #1;
    rsv_en = 1'b0; req = 3'b111; req_addr = a3; req_data = d3;
    #1;
    chk("rstC_pre_wr_en", wr_en, 1'b1);
    chk("rstC_pre_busyB", busy_B, SB);
    #1 n_reset = 1'b0;
    #1;
    chk("rstC_wr_en", wr_en, 1'b0);
    chk("rstC_ack", ack, 3'b000);
    chk("rstC_busyB", busy_B, 1'b0);
    chk("rstC_w_addr", w_addr, 5'd0);
    @(negedge clk);
    n_reset = 1'b1;
    #1 chk("rstC_first_grant", ack, 3'b001);
    $display("seq async_reset: first grant ack=%b", ack);
    req = 3'b000;
    @(posedge clk); #1;

    // Randomized traffic against the reference model.
    m_ptr = 0; m_wr = 1'b0; m_addr = '0; m_data = '0;
    for (int r = 0; r < 32; r++) m_busy[r] = 1'b0;
    for (int i = 0; i < N; i++) begin pend[i] = 1'b0; pa[i] = '0; pd[i] = '0; end
    for (int c = 0; c < 200; c++) begin
      for (int i = 0; i < N; i++) begin
        if (!pend[i] && $urandom_range(0, 2) != 0) begin
          pend[i] = 1'b1;
          pa[i] = ($urandom_range(0, 7) == 0) ? 5'd0 : 5'($urandom_range(1, 31));
          pd[i] = $urandom;
        end
        req[i] = pend[i];
        req_addr[i*W +: W] = pa[i];
        req_data[i*B +: B] = pd[i];
      end
      rsv_en   = ($urandom_range(0, 2) == 0);
      rsv_addr = 5'($urandom_range(0, 31));
      q_addr_A = 5'($urandom_range(0, 31));
      q_addr_B = (c % 2 == 0) ? m_addr : 5'($urandom_range(0, 31));
      #2;
      win = -1;
      for (int k = 0; k < N; k++) begin
        if (win < 0 && pend[(m_ptr + k) % N]) win = (m_ptr + k) % N;
      end
      exp_ack = '0;
      if (win >= 0) exp_ack[win] = 1'b1;
      chk($sformatf("rnd%0d_ack", c), ack, exp_ack);
      chk($sformatf("rnd%0d_busy_A", c), busy_A, SB & m_busy[q_addr_A]);
      chk($sformatf("rnd%0d_busy_B", c), busy_B, SB & m_busy[q_addr_B]);
      if (m_wr) m_busy[m_addr] = 1'b0;
      if (rsv_en && rsv_addr != 0) m_busy[rsv_addr] = 1'b1;
      if (win >= 0) begin
        m_wr   = (pa[win] != 0);
        m_addr = pa[win];
        m_data = pd[win];
        m_ptr  = (win + 1) % N;
        pend[win] = 1'b0;
        $display("rnd %0d grant=%0d addr=%0d data=%h", c, win, pa[win], pd[win]);
      end else begin
        m_wr = 1'b0;
      end
      @(posedge clk); #1;
      chk($sformatf("rnd%0d_wr_en", c), wr_en, m_wr);
      chk($sformatf("rnd%0d_w_addr", c), w_addr, m_addr);
      chk($sformatf("rnd%0d_w_data", c), w_data, m_data);
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/rf_wb_arbiter.md
# rf_wb_arbiter

Write-back arbiter and scoreboard for the 32×32 integer register file. Shares the register file's single write port between N write-back sources (ALU, load unit, CSR/misc) using round-robin arbitration. Drives the file's `wr_en`/`w_addr`/`w_data` from registered outputs. Optionally tracks in-flight destination registers so decode can stall on RAW hazards.

## Interface

**Parameters**
- `N`, default 3: number of write-back requesters (2..8).
- `W`, default 5: register address bits.
- `B`, default 32: data word width.

**Ports**
- `clk`, input, 1: rising-edge clock.
- `n_reset`, input, 1: asynchronous, active-low reset.
- `req`, input, N: per-requester write request. Held stable, with its address and data, until acked.
- `req_addr`, input, N*W: destination addresses; requester i occupies bits [i*W +: W].
- `req_data`, input, N*B: write data; requester i occupies bits [i*B +: B].
- `ack`, output, N: one-hot grant, combinational, same cycle as the granted `req`.
- `wr_en`, output, 1: register-file write enable (registered).
- `w_addr`, output, W: register-file write address (registered).
- `w_data`, output, B: register-file write data (registered).
- `rsv_en`, input, 1: decode reserves destination `rsv_addr` (scoreboard).
- `rsv_addr`, input, W: destination being reserved.
- `q_addr_A`, input, W: first scoreboard query address (rs1).
- `q_addr_B`, input, W: second scoreboard query address (rs2).
- `busy_A`, output, 1: combinational busy bit for `q_addr_A`.
- `busy_B`, output, 1: combinational busy bit for `q_addr_B`.

## Operation

**Arbitration**
- Each cycle, the first asserted `req[i]` searching upward from `rr_ptr`, wrapping modulo N, gets `ack[i]=1`.
- At most one `ack` bit is high per cycle.
- No `req` asserted: `ack=0`, `rr_ptr` unchanged.
- On a grant to i: `rr_ptr <= (i+1) mod N`. The pointer is 0 at reset.
- A requester deasserts `req` or presents its next transaction in the cycle after its ack.

**Write port**
- On a grant, the next edge loads `w_addr`/`w_data` from requester i.
- `wr_en` is set to 1 only if the address is nonzero.
- Writes to x0 are acked and dropped: `wr_en=0`.
- No grant: `wr_en <= 0`. `w_addr`/`w_data` hold their last values.

**Scoreboard** (when compiled in)
- One busy bit per register, 2**W bits total. Bit 0 is hard-wired 0.
- `rsv_en` with a nonzero `rsv_addr` sets the bit at the next edge.
- A committed write (`wr_en=1`) clears bit `w_addr` at the next edge.
- Reserve and commit to the same address in the same cycle: reserve wins, and the bit stays 1.
- `busy_A`/`busy_B` read the stored bits only. There is no bypass of the same-cycle commit.

## Timing

- Cycle t: `req[i]` sampled, `ack[i]` high.
- Cycle t+1: `wr_en`/`w_addr`/`w_data` valid. The register file commits at the edge closing t+1.
- Scoreboard bit clears at the same edge, so `busy` deasserts in cycle t+2.
- Write-port throughput is 1 write per cycle. Worst-case wait for any requester under full load is N-1 cycles.

**Reset** (async, any time):
- `wr_en=0`, `w_addr=0`, `w_data=0`, `rr_ptr=0`, all busy bits 0.
- `ack=0` while `n_reset` is low.
- A write in flight at reset assertion is lost. Requesters re-issue after reset.

## Configuration

- `RF_WB_SCOREBOARD_EN` defined: the busy array, `rsv_*`, `q_addr_*` and `busy_*` logic are built as described above.
- Macro undefined: `busy_A`/`busy_B` are tied to 0, `rsv_*`/`q_addr_*` are ignored, and no scoreboard flops are generated.
- The port list is identical in both builds.

## Structure

- Shared package `rf_pkg`: `RF_ADDR_W=5`, `RF_DATA_W=32`, `RF_WB_N=3`, and the requester-index constants `WB_ALU=0`, `WB_LSU=1`, `WB_MISC=2`.
- Sub-module `rr_arbiter`: parameterised N-way round-robin grant. Inputs are `req` and `rr_ptr`; outputs are the one-hot grant and the grant index.
- Pointer update, write-port registers and scoreboard live in `rf_wb_arbiter`.

## Test plan

- Reset, then `req=3'b000` for 4 cycles: `ack=0` and `wr_en=0` throughout; `rr_ptr` stays 0.
- Single request: `req[1]` with addr 7, data 0xDEADBEEF. `ack=3'b010` in cycle t. In t+1: `wr_en=1`, `w_addr=7`, `w_data=0xDEADBEEF`.
- All three requesting continuously: acks rotate 001, 010, 100, 001.
- Conflict after a grant to 0: with `req=3'b101`, requester 2 wins.
- x0 write: `req[0]` with addr 0, data 0x5. `ack[0]=1`, but `wr_en=0` in t+1.
- Scoreboard (with `RF_WB_SCOREBOARD_EN`): `rsv_en` on addr 5 gives `busy_A=1` for `q_addr_A=5`. A write-back to 5 then clears it two cycles after its ack. Reserve and commit of 5 in the same cycle keeps `busy_A=1`.
- Async reset asserted mid-cycle while `wr_en=1` and x9 is busy: immediately `wr_en=0`, `ack=0`, busy for 9 reads 0, and the next grant goes to requester 0.
